// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_sweep_ctrl : frequency-sweep controller driving a DDS increment      |
// | Optional: DDS_SWEEP_TRIANGLE_EN enables triangle (up/down) mode 10.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dds_sweep_ctrl #(
  parameter int accumulator_width = 32,
  parameter int dwell_width       = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_ce,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [1:0]                   i_mode,
  input  logic [accumulator_width-2:0] i_start_inc,
  input  logic [accumulator_width-2:0] i_stop_inc,
  input  logic [accumulator_width-2:0] i_step,
  input  logic [dwell_width-1:0]       i_dwell,
  output logic [accumulator_width-2:0] o_increment,
  output logic                         o_update,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int c_INC_W = accumulator_width - 1;
  localparam logic [dwell_width-1:0] c_CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [1:0]            r_mode;
  logic [c_INC_W-1:0]    r_start;
  logic [c_INC_W-1:0]    r_stop;
  logic [c_INC_W-1:0]    r_step;
  logic [dwell_width-1:0] r_dwell;
  logic [dwell_width-1:0] r_cnt;
  logic [c_INC_W-1:0]    r_inc;
  logic                  r_update;
  logic                  r_at_end;
  logic                  r_degen;

  logic                  w_latch;
  logic                  w_load;
  logic [c_INC_W-1:0]    w_load_val;
  logic [dwell_width-1:0] w_cnt_next;
  logic                  w_at_end_next;
  logic                  w_single;
  logic [c_INC_W:0]      w_sum;

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic                  r_dir_down;
  logic                  w_dir_down_next;
  logic                  w_tri;
  logic [c_INC_W:0]      w_diff;

  assign w_tri  = (r_mode == 2'b10);
  assign w_diff = {1'b0, r_inc} - {1'b0, r_step};
`endif

  assign w_single = (r_mode == 2'b00) || (r_mode == 2'b11);
  // One extra bit so an up-step past the top of the range is seen, not wrapped.
  assign w_sum    = {1'b0, r_inc} + {1'b0, r_step};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_latch       = 1'b0;
    w_load        = 1'b0;
    w_load_val    = r_inc;
    w_cnt_next    = r_cnt;
    w_at_end_next = r_at_end;
`ifdef DDS_SWEEP_TRIANGLE_EN
    w_dir_down_next = r_dir_down;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_latch       = 1'b1;
          w_load        = 1'b1;
          w_load_val    = i_start_inc;
          w_cnt_next    = i_dwell;
          w_at_end_next = 1'b0;
          w_next_state  = S_DWELL;
`ifdef DDS_SWEEP_TRIANGLE_EN
          w_dir_down_next = 1'b0;
`endif
        end
      end
      S_DWELL: begin
        if (i_ce) begin
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - c_CNT_ONE;
          end else if (r_at_end) begin
            // Stop value has had its dwell: finish, or wrap for sawtooth.
            if (w_single) begin
              w_next_state = S_DONE;
            end else begin
              w_load        = 1'b1;
              w_load_val    = r_start;
              w_cnt_next    = r_dwell;
              w_at_end_next = 1'b0;
            end
          end else if (r_degen) begin
            // Continuous modes park on start; single sweeps jump to stop.
            if (w_single) begin
              w_load        = 1'b1;
              w_load_val    = r_stop;
              w_cnt_next    = r_dwell;
              w_at_end_next = 1'b1;
            end
`ifdef DDS_SWEEP_TRIANGLE_EN
          end else if (r_dir_down) begin
            w_load     = 1'b1;
            w_cnt_next = r_dwell;
            if (w_diff[c_INC_W] || (w_diff[c_INC_W-1:0] <= r_start)) begin
              w_load_val      = r_start;
              w_dir_down_next = 1'b0;
            end else begin
              w_load_val = w_diff[c_INC_W-1:0];
            end
`endif
          end else if (w_sum >= {1'b0, r_stop}) begin
            w_load     = 1'b1;
            w_load_val = r_stop;
            w_cnt_next = r_dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
            if (w_tri) begin
              w_dir_down_next = 1'b1;
            end else begin
              w_at_end_next = 1'b1;
            end
`else
            w_at_end_next = 1'b1;
`endif
          end else begin
            w_load     = 1'b1;
            w_load_val = w_sum[c_INC_W-1:0];
            w_cnt_next = r_dwell;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (i_abort) begin
      w_next_state = S_IDLE;
      w_latch      = 1'b0;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_mode   <= 2'b00;
      r_start  <= '0;
      r_stop   <= '0;
      r_step   <= '0;
      r_dwell  <= '0;
      r_degen  <= 1'b0;
      r_inc    <= '0;
      r_update <= 1'b0;
      r_cnt    <= '0;
      r_at_end <= 1'b0;
    end else begin
      if (w_latch) begin
        r_mode  <= i_mode;
        r_start <= i_start_inc;
        r_stop  <= i_stop_inc;
        r_step  <= i_step;
        r_dwell <= i_dwell;
        r_degen <= (i_start_inc >= i_stop_inc) || (i_step == '0);
      end
      if (w_load) begin
        r_inc <= w_load_val;
      end
      r_update <= w_load;
      r_cnt    <= w_cnt_next;
      r_at_end <= w_at_end_next;
    end
  end

`ifdef DDS_SWEEP_TRIANGLE_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_dir_down <= 1'b0;
    end else begin
      r_dir_down <= w_dir_down_next;
    end
  end
`endif

  assign o_increment = r_inc;
  assign o_update    = r_update;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dds_sweep_ctrl : randomized self-checking bench for dds_sweep_ctrl    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dds_sweep_ctrl;

  localparam int IW = 31;
  localparam int DW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce    = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic [IW-1:0] s_inc = '0;
  logic [IW-1:0] e_inc = '0;
  logic [IW-1:0] step  = '0;
  logic [DW-1:0] dwell = '0;
  logic [IW-1:0] inc;
  logic          upd;
  logic          busy;
  logic          done;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            ce_ph   = 0;
  logic [IW-1:0] exp_q[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_ce        (ce),
    .i_start     (start),
    .i_abort     (abort),
    .i_mode      (mode),
    .i_start_inc (s_inc),
    .i_stop_inc  (e_inc),
    .i_step      (step),
    .i_dwell     (dwell),
    .o_increment (inc),
    .o_update    (upd),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ce(input int ce_div);
    if (ce_div == 0) begin
      ce = 1'($urandom_range(0, 1));
    end else begin
      ce = ((ce_ph % ce_div) == 0);
      ce_ph++;
    end
  endtask

  task automatic scramble();
    mode  = 2'($urandom);
    s_inc = IW'($urandom);
    e_inc = IW'($urandom);
    step  = IW'($urandom);
    dwell = DW'($urandom);
  endtask

  // Reference list of increment values a sweep must produce, in order.
  task automatic build_exp(input logic [1:0] m, input logic [IW-1:0] s, input logic [IW-1:0] e,
                           input logic [IW-1:0] st, input int maxn);
    logic [IW:0] v;
    logic [IW:0] nx;
    bit          up;
    bit          cont;
    bit          tri_m;
    exp_q.delete();
    cont = (m == 2'b01) || (m == 2'b10);
`ifdef DDS_SWEEP_TRIANGLE_EN
    tri_m = (m == 2'b10);
`else
    tri_m = 1'b0;
`endif
    exp_q.push_back(s);
    if (s >= e || st == '0) begin
      if (!cont) exp_q.push_back(e);
      return;
    end
    v  = {1'b0, s};
    up = 1'b1;
    while (exp_q.size() < maxn) begin
      if (up) begin
        nx = v + {1'b0, st};
        if (nx >= {1'b0, e}) begin
          exp_q.push_back(e);
          if (!cont) return;
          if (tri_m) begin
            up = 1'b0;
            v  = {1'b0, e};
          end else begin
            exp_q.push_back(s);
            v = {1'b0, s};
          end
        end else begin
          exp_q.push_back(nx[IW-1:0]);
          v = nx;
        end
      end else begin
        if (v < {1'b0, st} || (v - {1'b0, st}) <= {1'b0, s}) begin
          exp_q.push_back(s);
          v  = {1'b0, s};
          up = 1'b1;
        end else begin
          v = v - {1'b0, st};
          exp_q.push_back(v[IW-1:0]);
        end
      end
    end
  endtask

  // n_abort == 0: single sweep run to completion; otherwise abort (with a
  // simultaneous start) once n_abort values have appeared.
  task automatic run_sweep(input logic [1:0] m, input logic [IW-1:0] s, input logic [IW-1:0] e,
                           input logic [IW-1:0] st, input logic [DW-1:0] dw,
                           input int ce_div, input int n_abort);
    int            idx;
    int            cnt;
    int            cyc;
    int            target;
    int            hold;
    int            budget;
    bit            fin;
    bit            ce_s;
    bit            ab;
    bit            degen_cont;
    logic [IW-1:0] last;
    build_exp(m, s, e, st, (n_abort > 0) ? n_abort : 1000000);
    degen_cont = (s >= e || st == '0) && (m == 2'b01 || m == 2'b10);
    target = exp_q.size();
    if (n_abort > 0 && n_abort < target) target = n_abort;
    hold   = degen_cont ? 3 * (int'(dw) + 1) : int'(dw);
    budget = (exp_q.size() + 4) * (int'(dw) + 1) * 16 + 200;
    ce_ph  = 0;
    mode = m; s_inc = s; e_inc = e; step = st; dwell = dw; start = 1'b1;
    drive_ce(ce_div);
    tick();
    start = 1'b0;
    scramble();
    check("start_update", 64'(upd), 64'd1);
    check("start_value", 64'(inc), 64'(exp_q[0]));
    check("start_busy", 64'(busy), 64'd1);
    idx = 1; cnt = 0; cyc = 0; last = exp_q[0]; fin = 1'b0;
    while (!fin) begin
      drive_ce(ce_div);
      ab = (n_abort > 0) && (idx == target) && (cnt == hold);
      if (ab) begin
        abort = 1'b1;
        start = 1'b1;
      end else begin
        start = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk);
      ce_s = ce;
      #1;
      abort = 1'b0;
      start = 1'b0;
      cyc++;
      budget--;
      if (ab) begin
        check("abort_update", 64'(upd), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hold", 64'(inc), 64'(last));
        fin = 1'b1;
      end else begin
        if (ce_s) cnt++;
        if (upd) begin
          if (idx < target) begin
            check("step_value", 64'(inc), 64'(exp_q[idx]));
            check("dwell_ce", 64'(cnt), 64'(dw) + 64'd1);
            if (ce_div > 1 && idx > 1) check("dwell_clk", 64'(cyc), (64'(dw) + 64'd1) * 64'(ce_div));
            last = exp_q[idx];
          end else begin
            check("extra_update", 64'd1, 64'd0);
          end
          idx++;
          cnt = 0;
          cyc = 0;
        end
        if (done) begin
          if (n_abort > 0) begin
            check("early_done", 64'd1, 64'd0);
          end else begin
            check("done_index", 64'(idx), 64'(target));
            check("done_dwell", 64'(cnt), 64'(dw) + 64'd1);
            check("done_update", 64'(upd), 64'd0);
          end
          tick();
          check("idle_busy", 64'(busy), 64'd0);
          check("idle_done", 64'(done), 64'd0);
          check("idle_hold", 64'(inc), 64'(last));
          fin = 1'b1;
        end
        if (!fin && budget <= 0) begin
          check("timeout", 64'd1, 64'd0);
          abort = 1'b1;
          tick();
          abort = 1'b0;
          fin = 1'b1;
        end
      end
    end
    ce = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0]    m;
    logic [IW-1:0] s;
    logic [IW-1:0] e;
    logic [IW-1:0] st;
    logic [DW-1:0] dw;
    int            n_ab;

    repeat (3) tick();
    check("reset_inc", 64'(inc), 64'd0);
    check("reset_update", 64'(upd), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    run_sweep(2'b00, 31'd100, 31'd130, 31'd10, 16'd2, 1, 0);
    run_sweep(2'b10, 31'd0, 31'd20, 31'd10, 16'd0, 1, 7);
    run_sweep(2'b00, 31'h7FFF_FFF0, 31'h7FFF_FFFF, 31'h20, 16'd0, 1, 0);
    run_sweep(2'b00, 31'd5, 31'd50, 31'd15, 16'd1, 4, 0);
    run_sweep(2'b01, 31'd10, 31'd60, 31'd7, 16'd1, 0, 5);
    run_sweep(2'b01, 31'd50, 31'd50, 31'd3, 16'd1, 1, 1);
    run_sweep(2'b10, 31'd10, 31'd40, 31'd0, 16'd0, 1, 1);
    run_sweep(2'b11, 31'd40, 31'd10, 31'd5, 16'd0, 1, 0);

    // Reset in the middle of a running sweep.
    mode = 2'b01; s_inc = 31'd10; e_inc = 31'd90; step = 31'd5; dwell = 16'd1;
    start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_inc", 64'(inc), 64'd0);
    check("midrst_update", 64'(upd), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();
    check("postrst_busy", 64'(busy), 64'd0);
    ce = 1'b0;

    for (int t = 0; t < 30; t++) begin
      m  = 2'($urandom);
      s  = IW'($urandom_range(0, 100));
      e  = IW'($urandom_range(0, 150));
      st = ($urandom_range(0, 6) == 0) ? '0 : IW'($urandom_range(1, 30));
      dw = DW'($urandom_range(0, 3));
      if (m == 2'b01 || m == 2'b10) n_ab = $urandom_range(1, 12);
      else n_ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      run_sweep(m, s, e, st, dw, ($urandom_range(0, 1) == 0) ? 0 : 1, n_ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
